ov7670_pixel_pack: RTL and testbench

Packs the camera capture stage's byte stream (8-bit data, valid strobe, end-of-frame pulse) into 16-bit RGB565 pixels. Generates linear frame-buffer write addresses and flags malformed lines and frames. Sits directly downstream of the OV7670 capture stage in the PCLK domain and drives the frame-buffer write port.

---
 rtl/ov7670_pkg.sv | 14 +
 rtl/ov7670_byte_pair.sv | 63 ++++++
 rtl/ov7670_pixel_pack.sv | 200 ++++++++++++++++++++
 tb/tb_ov7670_pixel_pack.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_pkg.sv
// Shared constants and state encoding for the OV7670 pixel packing path.
package ov7670_pkg;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned PIX_W        = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SYNC    = 2'd1,
        CAPTURE = 2'd2
    } state_e;

endpackage

// File: rtl/ov7670_byte_pair.sv
// Pairs consecutive capture bytes into one RGB565 pixel; the phase bit marks a
// half-assembled pixel so the caller can judge line completeness.
module ov7670_byte_pair
    import ov7670_pkg::*;
#(
    parameter bit BYTE_SWAP = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             byte_valid_i,
    input  logic [7:0]       byte_i,
    output logic             phase_o,
    output logic             pixel_valid_o,
    output logic [PIX_W-1:0] pixel_o
);

    logic       phase_q, phase_d;
    logic [7:0] stored_q, stored_d;

    // Next phase and stored byte; clear drops any half pixel
    always_comb begin
        phase_d  = phase_q;
        stored_d = stored_q;
        if (clr_i) begin
            phase_d  = 1'b0;
            stored_d = 8'd0;
        end else if (byte_valid_i) begin
            phase_d = ~phase_q;
            if (!phase_q) begin
                stored_d = byte_i;
            end else begin
                stored_d = stored_q;
            end
        end else begin
            phase_d  = phase_q;
            stored_d = stored_q;
        end
    end

    // Phase and stored-byte registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q  <= 1'b0;
            stored_q <= 8'd0;
        end else begin
            phase_q  <= phase_d;
            stored_q <= stored_d;
        end
    end

    // Pixel assembly from the stored byte and the current one
    always_comb begin
        pixel_valid_o = byte_valid_i & phase_q & ~clr_i;
        phase_o       = phase_q;
        if (BYTE_SWAP) begin
            pixel_o = {byte_i, stored_q};
        end else begin
            pixel_o = {stored_q, byte_i};
        end
    end

endmodule

// File: rtl/ov7670_pixel_pack.sv
// Packs capture bytes into RGB565 pixels, generates linear frame-buffer
// addresses with an accumulator, and flags malformed lines and frames.
module ov7670_pixel_pack
    import ov7670_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE  = V_ACTIVE_DEF,
    parameter int unsigned ADDR_W    = 19,
    parameter bit          BYTE_SWAP = 1'b0
) (
    input  logic              PCLK,
    input  logic              RESET,
    input  logic [7:0]        din,
    input  logic              din_valid,
    input  logic              frame_done,
    input  logic              enable,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic              frame_ready,
    output logic              line_err,
    output logic              frame_err
);

    localparam int unsigned XW = $clog2(H_ACTIVE + 1);
    localparam int unsigned YW = $clog2(V_ACTIVE + 1);
    localparam logic [XW-1:0]     X_MAX  = XW'(H_ACTIVE);
    localparam logic [YW-1:0]     Y_MAX  = YW'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_ACTIVE);

    state_e              state_q, state_d;
    logic [XW-1:0]       x_q, x_d;
    logic [YW-1:0]       y_q, y_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic                fd_prev_q, dv_prev_q;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [PIX_W-1:0]    wr_data_q, wr_data_d;
    logic                frame_ready_q, frame_ready_d;
    logic                line_err_q, line_err_d;
    logic                frame_err_q, frame_err_d;

    logic                in_cap_s, fd_rise_s, accept_s, frame_end_s;
    logic                close_line_s, pair_clr_s;
    logic                phase_s, pix_valid_s;
    logic [PIX_W-1:0]    pixel_s;

    // Event decode; a byte coinciding with a frame end is dropped
    always_comb begin
        in_cap_s     = (state_q == CAPTURE);
        fd_rise_s    = frame_done & ~fd_prev_q;
        accept_s     = in_cap_s & din_valid & ~fd_rise_s;
        frame_end_s  = in_cap_s & fd_rise_s;
        close_line_s = in_cap_s & dv_prev_q & (~din_valid | fd_rise_s);
        pair_clr_s   = ~in_cap_s | close_line_s | frame_end_s;
    end

    ov7670_byte_pair #(
        .BYTE_SWAP(BYTE_SWAP)
    ) u_pair (
        .clk_i        (PCLK),
        .rst_i        (RESET),
        .clr_i        (pair_clr_s),
        .byte_valid_i (accept_s),
        .byte_i       (din),
        .phase_o      (phase_s),
        .pixel_valid_o(pix_valid_s),
        .pixel_o      (pixel_s)
    );

    // Next-state logic for FSM, counters, address accumulator and outputs
    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        base_d        = base_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        frame_ready_d = 1'b0;
        line_err_d    = line_err_q;
        frame_err_d   = frame_err_q;
        case (state_q)
            IDLE: begin
                x_d    = '0;
                y_d    = '0;
                base_d = '0;
                if (enable) begin
                    state_d     = SYNC;
                    line_err_d  = 1'b0;
                    frame_err_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            SYNC: begin
                x_d    = '0;
                y_d    = '0;
                base_d = '0;
                if (!enable) begin
                    state_d = IDLE;
                end else if (fd_rise_s) begin
                    state_d = CAPTURE;
                end else begin
                    state_d = SYNC;
                end
            end
            CAPTURE: begin
                // Any byte on a line past the last one marks the frame bad
                frame_err_d = frame_err_q | (accept_s & (y_q >= Y_MAX));
                if (pix_valid_s) begin
                    if ((x_q < X_MAX) && (y_q < Y_MAX)) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = base_q + ADDR_W'(x_q);
                        wr_data_d = pixel_s;
                    end else begin
                        wr_en_d = 1'b0;
                    end
                    if (x_q < X_MAX) begin
                        x_d = x_q + XW'(1'b1);
                    end else begin
                        x_d        = x_q;
                        line_err_d = 1'b1;
                    end
                end else begin
                    x_d = x_q;
                end
                if (close_line_s) begin
                    line_err_d = line_err_d | (x_q != X_MAX) | phase_s;
                    x_d        = '0;
                    if (y_q < Y_MAX) begin
                        y_d    = y_q + YW'(1'b1);
                        base_d = base_q + H_STEP;
                    end else begin
                        y_d    = y_q;
                        base_d = base_q;
                    end
                end else begin
                    y_d    = y_q;
                    base_d = base_q;
                end
                if (frame_end_s) begin
                    frame_err_d   = frame_err_d | (y_d != Y_MAX);
                    frame_ready_d = 1'b1;
                    x_d           = '0;
                    y_d           = '0;
                    base_d        = '0;
                    state_d       = enable ? CAPTURE : IDLE;
                end else begin
                    state_d = CAPTURE;
                end
            end
            default: begin
                state_d = IDLE;
                x_d     = '0;
                y_d     = '0;
                base_d  = '0;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge PCLK) begin
        if (RESET) begin
            state_q       <= IDLE;
            x_q           <= '0;
            y_q           <= '0;
            base_q        <= '0;
            fd_prev_q     <= 1'b0;
            dv_prev_q     <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            frame_ready_q <= 1'b0;
            line_err_q    <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            base_q        <= base_d;
            fd_prev_q     <= frame_done;
            dv_prev_q     <= accept_s;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            frame_ready_q <= frame_ready_d;
            line_err_q    <= line_err_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign frame_ready = frame_ready_q;
    assign line_err    = line_err_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_ov7670_pixel_pack.sv
// Self-checking bench: two instances (BYTE_SWAP 0 and 1) share stimulus and are
// compared against a frame-level model built from line lengths and byte values.
module tb_ov7670_pixel_pack;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int AW = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [7:0]       din = 8'd0;
    logic             dv  = 1'b0;
    logic             fd  = 1'b0;
    logic             en  = 1'b0;
    logic [1:0]       wr_en, fr, le, fe;
    logic [AW-1:0]    wa [2];
    logic [15:0]      wd [2];

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ov7670_pixel_pack #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .BYTE_SWAP(1'b0)) u0 (
        .PCLK(clk), .RESET(rst), .din(din), .din_valid(dv), .frame_done(fd), .enable(en),
        .wr_en(wr_en[0]), .wr_addr(wa[0]), .wr_data(wd[0]), .frame_ready(fr[0]),
        .line_err(le[0]), .frame_err(fe[0]));

    ov7670_pixel_pack #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .BYTE_SWAP(1'b1)) u1 (
        .PCLK(clk), .RESET(rst), .din(din), .din_valid(dv), .frame_done(fd), .enable(en),
        .wr_en(wr_en[1]), .wr_addr(wa[1]), .wr_data(wd[1]), .frame_ready(fr[1]),
        .line_err(le[1]), .frame_err(fe[1]));

    typedef struct {
        int            c;
        logic [AW-1:0] a;
        logic [15:0]   d0;
        logic [15:0]   d1;
    } wr_t;

    wr_t         expq [$];
    int          errors = 0;
    int          checks = 0;
    int          fr_cnt [2];
    int          fr_exp_cyc = -1;
    int          frames = 0;
    bit          exp_le = 1'b0;
    bit          exp_fe = 1'b0;
    logic [15:0] mem [2][8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare process: every write and frame_ready pulse against the model
    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (fr[s]) begin
                fr_cnt[s]++;
                chk("frame_ready_cycle", cyc, fr_exp_cyc);
            end
        end
        if (expq.size() > 0 && expq[0].c < cyc) begin
            chk("write_missing_at", cyc, expq[0].c);
            void'(expq.pop_front());
        end
        if (wr_en != 2'b00) begin
            if (expq.size() == 0) begin
                chk("unexpected_wr_en", {30'd0, wr_en}, 32'd0);
            end else begin
                wr_t e;
                e = expq.pop_front();
                chk("write_cycle", cyc, e.c);
                for (int s = 0; s < 2; s++) begin
                    chk("wr_en", {31'd0, wr_en[s]}, 32'd1);
                    chk("wr_addr", {29'd0, wa[s]}, {29'd0, e.a});
                    chk(s == 0 ? "wr_data_noswap" : "wr_data_swap", {16'd0, wd[s]},
                        {16'd0, (s == 0) ? e.d0 : e.d1});
                    mem[s][wa[s]] = wd[s];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        for (int s = 0; s < 2; s++) begin
            chk({tag, "_wr_en"}, {31'd0, wr_en[s]}, 32'd0);
            chk({tag, "_wr_addr"}, {29'd0, wa[s]}, 32'd0);
            chk({tag, "_wr_data"}, {16'd0, wd[s]}, 32'd0);
            chk({tag, "_frame_ready"}, {31'd0, fr[s]}, 32'd0);
            chk({tag, "_line_err"}, {31'd0, le[s]}, 32'd0);
            chk({tag, "_frame_err"}, {31'd0, fe[s]}, 32'd0);
        end
    endtask

    task automatic clear_mem();
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 8; a++)
                mem[s][a] = 16'hDEAD;
    endtask

    // Reset, enable, optional bytes while waiting, then the synchronising frame_done
    task automatic start(input int sync_bytes, input int sync_hold);
        rst = 1'b1; en = 1'b0; dv = 1'b0; fd = 1'b0;
        tick(); tick();
        rst = 1'b0;
        expq.delete();
        fr_cnt[0] = 0; fr_cnt[1] = 0;
        frames = 0; exp_le = 1'b0; exp_fe = 1'b0; fr_exp_cyc = -1;
        check_idle_outputs("reset");
        en = 1'b1;
        tick(); tick();
        for (int j = 0; j < sync_bytes; j++) begin
            din = 8'($urandom); dv = 1'b1; tick();
        end
        dv = 1'b0;
        tick();
        fd = 1'b1;
        for (int h = 0; h < sync_hold; h++) tick();
        fd = 1'b0;
        tick();
    endtask

    // Drive one line; model: pixel i of line k goes to k*H+i when inside the frame
    task automatic send_line(input int k, input int n, input bit seq);
        logic [7:0] prev, b;
        prev = 8'd0;
        for (int j = 0; j < n; j++) begin
            b = seq ? 8'(j + 1) : 8'($urandom);
            din = b; dv = 1'b1;
            if ((j % 2) == 1 && (j / 2) < H && k < V) begin
                wr_t e;
                e.c  = cyc + 1;
                e.a  = AW'(k * H + j / 2);
                e.d0 = {prev, b};
                e.d1 = {b, prev};
                expq.push_back(e);
            end
            prev = b;
            tick();
        end
    endtask

    // mode 0: gap then frame_done; 1: frame_done on the line-end cycle; 2: with a dropped byte
    task automatic send_frame(input int nl, input int lens [4], input int mode,
                              input int hold, input bit seq);
        for (int k = 0; k < nl; k++) begin
            send_line(k, lens[k], seq);
            if (k < nl - 1) begin
                dv = 1'b0; tick();
            end
            if (lens[k] != 2 * H) exp_le = 1'b1;
        end
        if (nl != V) exp_fe = 1'b1;
        frames++;
        if (mode == 0) begin
            dv = 1'b0; tick();
            fd = 1'b1;
        end else if (mode == 1) begin
            dv = 1'b0; fd = 1'b1;
        end else begin
            dv = 1'b1; din = 8'($urandom); fd = 1'b1;
        end
        fr_exp_cyc = cyc + 1;
        tick();
        dv = 1'b0;
        for (int h = 1; h < hold; h++) tick();
        fd = 1'b0;
        tick();
        for (int s = 0; s < 2; s++) begin
            chk("frame_ready_count", fr_cnt[s], frames);
            chk("line_err", {31'd0, le[s]}, {31'd0, exp_le});
            chk("frame_err", {31'd0, fe[s]}, {31'd0, exp_fe});
        end
        chk("pending_writes", expq.size(), 0);
    endtask

    initial begin
        int choice [8];
        int lens [4];
        choice = '{8, 8, 8, 7, 9, 6, 10, 2};

        // Nominal frame, sequential bytes
        clear_mem();
        start(0, 1);
        send_frame(2, '{8, 8, 0, 0}, 0, 1, 1'b1);
        chk("pin_addr0_noswap", {16'd0, mem[0][0]}, 32'h0102);
        chk("pin_addr3_noswap", {16'd0, mem[0][3]}, 32'h0708);
        chk("pin_addr5_noswap", {16'd0, mem[0][5]}, 32'h0304);
        chk("pin_addr0_swap",   {16'd0, mem[1][0]}, 32'h0201);
        chk("pin_addr7_swap",   {16'd0, mem[1][7]}, 32'h0807);

        // Short line then long line
        clear_mem();
        start(0, 1);
        send_frame(2, '{7, 10, 0, 0}, 0, 1, 1'b1);
        chk("pin_addr2", {16'd0, mem[0][2]}, 32'h0506);
        chk("pin_addr3_unwritten", {16'd0, mem[0][3]}, 32'hDEAD);
        chk("pin_addr7_line1", {16'd0, mem[0][7]}, 32'h0708);

        // Too many lines
        start(0, 1);
        send_frame(3, '{8, 8, 8, 0}, 0, 1, 1'b1);

        // Bytes while synchronising, long frame_done pulses
        start(6, 5);
        send_frame(2, '{8, 8, 0, 0}, 0, 5, 1'b1);

        // Enable dropped: leave at the frame end, flags clear on re-enable
        start(0, 1);
        send_frame(2, '{7, 8, 0, 0}, 1, 1, 1'b1);
        en = 1'b0;
        send_frame(2, '{8, 8, 0, 0}, 0, 1, 1'b0);
        din = 8'h55; dv = 1'b1; tick(); tick();
        dv = 1'b0; tick();
        for (int s = 0; s < 2; s++) chk("idle_keeps_line_err", {31'd0, le[s]}, 32'd1);
        en = 1'b1;
        tick(); tick();
        for (int s = 0; s < 2; s++) begin
            chk("reenable_line_err", {31'd0, le[s]}, 32'd0);
            chk("reenable_frame_err", {31'd0, fe[s]}, 32'd0);
        end

        // Reset in the middle of a line
        start(0, 1);
        send_frame(2, '{9, 8, 0, 0}, 2, 1, 1'b1);
        send_line(0, 3, 1'b1);
        rst = 1'b1; din = 8'd4; dv = 1'b1;
        tick();
        check_idle_outputs("midline_reset");
        rst = 1'b0;
        for (int j = 0; j < 4; j++) begin
            din = 8'(j + 5); tick();
        end
        dv = 1'b0; tick();
        for (int s = 0; s < 2; s++) begin
            chk("post_reset_line_err", {31'd0, le[s]}, 32'd0);
            chk("post_reset_frame_err", {31'd0, fe[s]}, 32'd0);
        end
        chk("post_reset_pending", expq.size(), 0);

        // Randomised sessions
        for (int r = 0; r < 12; r++) begin
            start(int'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
            for (int f = 0; f < int'($urandom_range(1, 2)); f++) begin
                int nl;
                nl = int'($urandom_range(1, 3));
                for (int k = 0; k < 4; k++) lens[k] = choice[$urandom_range(0, 7)];
                send_frame(nl, lens, int'($urandom_range(0, 2)), int'($urandom_range(1, 3)), 1'b0);
            end
        end

        chk("final_pending_writes", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
